// File: rtl/skel_pkg.sv
// Shared types for the skeleton writeback block: FSM states, pixel type and
// the frame-border test used to clear edge pixels before writeback.
package skel_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef logic [7:0] pixel_t;

  // True when a row-major address lies on the outer ring of an n x n frame.
  function automatic logic is_border(input int unsigned addr, input int unsigned n);
    int unsigned row;
    int unsigned col;
    row = addr / n;
    col = addr % n;
    return (row == 0) || (row == n - 1) || (col == 0) || (col == n - 1);
  endfunction

endpackage

// File: rtl/skeleton_writeback.sv
// Writes thinned pixels back into the frame RAM only where they differ from the
// stored value. Optional pass limit enabled by macro SKEL_WB_ITER_LIMIT_EN.
module skeleton_writeback
  import skel_pkg::*;
#(
  parameter int N        = 8,
  parameter int bitSize  = 6,
  parameter int MAX_ITER = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [bitSize:0]   res_addr,
  input  pixel_t             res_data,
  output logic [bitSize:0]   mem_addr,
  input  pixel_t             mem_rdata,
  output logic               mem_we,
  output pixel_t             mem_wdata,
  output logic               busy,
  output logic               pass_done,
  output logic [bitSize+1:0] changed_count,
  output logic               converged,
  output logic [7:0]         iter_count
);

  localparam int CW    = bitSize + 2;
  localparam int TOTAL = N * N;

  state_t           state_q;
  logic [bitSize:0] addr_q;
  pixel_t           pix_q;
  logic [CW-1:0]    taken_q;
  logic [CW-1:0]    changed_q;
  logic [CW-1:0]    changed_d;
  logic             conv_q;
  logic [7:0]       iter_q;
  logic [7:0]       iter_d;
  logic             wr_hit;
  logic             start_blocked;
  logic             limit_hit;

`ifdef SKEL_WB_ITER_LIMIT_EN
  assign start_blocked = int'(iter_q) >= MAX_ITER;
  assign limit_hit     = int'(iter_d) >= MAX_ITER;
`else
  assign start_blocked = 1'b0;
  assign limit_hit     = 1'b0;
`endif

  // mem_rdata belongs to the address registered on accept, so the compare
  // and the write strobe resolve combinationally inside the CHECK cycle.
  assign wr_hit    = (state_q == S_CHECK) && (pix_q != mem_rdata);
  assign changed_d = changed_q + CW'(wr_hit);
  assign iter_d    = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      pix_q     <= '0;
      taken_q   <= '0;
      changed_q <= '0;
      conv_q    <= 1'b0;
      iter_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !start_blocked) begin
            state_q   <= S_ACCEPT;
            taken_q   <= '0;
            changed_q <= '0;
            conv_q    <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (res_valid) begin
            addr_q  <= res_addr;
            pix_q   <= is_border(32'(res_addr), N) ? 8'h00 : res_data;
            taken_q <= taken_q + CW'(1);
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          changed_q <= changed_d;
          if (int'(taken_q) < TOTAL) begin
            state_q <= S_ACCEPT;
          end else begin
            state_q <= S_DONE;
            iter_q  <= iter_d;
            conv_q  <= (changed_d == '0) || limit_hit;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_ready     = (state_q == S_ACCEPT);
  assign busy          = (state_q != S_IDLE);
  assign pass_done     = (state_q == S_DONE);
  assign mem_addr      = addr_q;
  assign mem_we        = wr_hit;
  assign mem_wdata     = wr_hit ? pix_q : 8'h00;
  assign changed_count = changed_q;
  assign converged     = conv_q;
  assign iter_count    = iter_q;

endmodule

// File: tb/tb_skeleton_writeback.sv
// Randomised bench for skeleton_writeback against a frame-level reference model.
module tb_skeleton_writeback;
  localparam int N     = 8;
  localparam int BS    = 6;
  localparam int MAXI  = 2;
  localparam int TOTAL = N * N;
`ifdef SKEL_WB_ITER_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [BS:0]   res_addr = '0;
  logic [7:0]    res_data = '0;
  logic [BS:0]   mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          pass_done;
  logic [BS+1:0] changed_count;
  logic          converged;
  logic [7:0]    iter_count;

  skeleton_writeback #(.N(N), .bitSize(BS), .MAX_ITER(MAXI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
    .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .pass_done(pass_done),
    .changed_count(changed_count), .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame RAM: mem_addr is the RAM's address register, data follows it.
  logic [7:0] ram      [0:127];
  logic [7:0] ram_init [0:127];
  logic [7:0] exp_ram  [0:127];
  logic       ram_load = 1'b0;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (ram_load) ram <= ram_init;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  int         res_a [0:TOTAL-1];
  logic [7:0] res_d [0:TOTAL-1];
  int         exp_wa[$];
  logic [7:0] exp_wd[$];
  bit         wr_chk_en = 1'b1;
  bit         acc_pend = 1'b0;
  int         acc_addr = 0;
  int         acc_cnt = 0;
  int         exp_iter = 0;
  int         pass_no = 0;

  // Write and accept monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_pend = 1'b0;
    end else begin
      if (mem_we && wr_chk_en) begin
        if (exp_wa.size() == 0) begin
          check("unexpected_write", {25'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", {25'd0, mem_addr}, exp_wa.pop_front());
          check("wr_data", {24'd0, mem_wdata}, {24'd0, exp_wd.pop_front()});
        end
      end
      if (acc_pend) begin
        check("mem_addr_follow", {25'd0, mem_addr}, acc_addr);
        acc_pend = 1'b0;
      end
      if (res_valid && res_ready) begin
        acc_pend = 1'b1;
        acc_addr = int'(res_addr);
        acc_cnt++;
      end
    end
  end

  function automatic bit border(input int a);
    return (a / N == 0) || (a / N == N - 1) || (a % N == 0) || (a % N == N - 1);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load_ram();
    @(posedge clk); #1 ram_load = 1'b1;
    @(posedge clk); #1 ram_load = 1'b0;
    for (int i = 0; i < 128; i++) exp_ram[i] = ram_init[i];
  endtask

  task automatic drive_results(input int n, input bit hold, input bit mid_start);
    int  i = 0;
    int  budget = 20 * n + 20;
    int  toggle_err = 0;
    bit  prev_ready = 1'b0;
    while (i < n && budget > 0) begin
      @(posedge clk); #1;
      res_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      res_addr  = (BS+1)'(res_a[i]);
      res_data  = res_d[i];
      start     = mid_start && ($urandom_range(0, 4) == 0);
      @(negedge clk);
      if (hold && (res_ready == prev_ready)) toggle_err++;
      prev_ready = res_ready;
      if (res_valid && res_ready) i++;
      budget--;
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    start     = 1'b0;
    check("results_taken", i, n);
    if (hold) check("ready_toggle_errs", toggle_err, 0);
  endtask

  task automatic run_pass(input bit hold, input bit mid_start);
    int  cnt = 0;
    bit  exp_conv;
    bit  seen = 1'b0;
    int  mism = 0;
    bit  blocked = LIM && (exp_iter >= MAXI);
    load_ram();
    pass_no++;
    if (blocked) begin
      pulse_start();
      repeat (3) @(negedge clk);
      check("blocked_busy", busy, 0);
      check("blocked_iter", iter_count, exp_iter);
      $display("pass %0d: start ignored, iter_count=%0d", pass_no, iter_count);
      return;
    end
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 0; i < TOTAL; i++) begin
      logic [7:0] v;
      v = border(res_a[i]) ? 8'h00 : res_d[i];
      if (v != exp_ram[res_a[i]]) begin
        exp_wa.push_back(res_a[i]);
        exp_wd.push_back(v);
        exp_ram[res_a[i]] = v;
        cnt++;
      end
    end
    exp_iter = (exp_iter < 255) ? exp_iter + 1 : 255;
    exp_conv = (cnt == 0) || (LIM && exp_iter >= MAXI);
    acc_cnt = 0;
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    drive_results(TOTAL, hold, mid_start);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pass_done) seen = 1'b1;
    end
    check("pass_done_seen", seen, 1);
    @(negedge clk);
    check("pass_done_pulse", pass_done, 0);
    check("busy_end", busy, 0);
    check("changed_count", changed_count, cnt);
    check("converged", converged, exp_conv);
    check("iter_count", iter_count, exp_iter);
    check("writes_left", exp_wa.size(), 0);
    check("accept_count", acc_cnt, TOTAL);
    for (int i = 0; i < TOTAL; i++) if (ram[i] != exp_ram[i]) mism++;
    check("ram_contents", mism, 0);
    $display("pass %0d: changed=%0d converged=%0d iter=%0d", pass_no,
             changed_count, converged, iter_count);
  endtask

  task automatic set_zero_frame();
    for (int i = 0; i < 128; i++) ram_init[i] = 8'h00;
    for (int i = 0; i < TOTAL; i++) begin
      res_a[i] = i;
      res_d[i] = 8'h00;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) ram_init[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", res_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", pass_done, 0);
    check("rst_changed", changed_count, 0);
    check("rst_conv", converged, 0);
    check("rst_iter", iter_count, 0);
    rst_n = 1'b1;

    // res_valid without a pass must have no effect.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      res_valid = 1'b1;
      res_addr  = 7'(27 + i);
      res_data  = 8'(32'($urandom));
      @(negedge clk);
      check("idle_ready", res_ready, 0);
      check("idle_busy", busy, 0);
    end
    @(posedge clk); #1 res_valid = 1'b0;
    $display("idle res_valid ignored");

    set_zero_frame();
    run_pass(1'b0, 1'b0);

    // Reset during CHECK of address 30 with a write pending.
    set_zero_frame();
    ram_init[30] = 8'h55;
    load_ram();
    wr_chk_en = 1'b0;
    pulse_start();
    drive_results(31, 1'b0, 1'b0);
    check("pending_we", mem_we, 1);
    check("pending_addr", mem_addr, 30);
    rst_n = 1'b0;
    #1;
    check("midrst_we", mem_we, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_wdata", mem_wdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", res_ready, 0);
    check("midrst_iter", iter_count, 0);
    check("midrst_changed", changed_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("no_partial_write", ram[30], 8'h55);
    rst_n = 1'b1;
    wr_chk_en = 1'b1;
    exp_iter = 0;
    $display("reset mid-pass at addr 30");

    set_zero_frame();
    run_pass(1'b0, 1'b0);

    // One interior change at 27, border result at 0 forced to zero.
    set_zero_frame();
    ram_init[27] = 8'hFF;
    res_d[0] = 8'hFF;
    run_pass(1'b1, 1'b0);
    if (exp_iter == 2) check("req_one_change", changed_count, 1);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < TOTAL; i++) ram_init[i] = 8'(32'($urandom));
      for (int i = 0; i < TOTAL; i++) begin
        res_a[i] = $urandom_range(0, TOTAL - 1);
        res_d[i] = ($urandom_range(0, 2) == 0) ? ram_init[res_a[i]] : 8'(32'($urandom));
      end
      run_pass(p == 1, p != 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
